mtl_scan_timing: RTL and testbench

//  Raster scan generator for the MTL 800x480 panel. Drives the x_cnt/y_cnt beam

---
 rtl/mtl_scan_timing.sv | 128 ++++++++++++
 tb/tb_mtl_scan_timing.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mtl_scan_timing.sv
`default_nettype none
// mtl_scan_timing: raster scan, sync/DE decode and frame-synchronous cube offset registers
// for the MTL 800x480 panel.
module mtl_scan_timing #(
  parameter int H_SYNC = 30,
  parameter int H_BP   = 16,
  parameter int H_ACT  = 800,
  parameter int H_FP   = 210,
  parameter int V_SYNC = 13,
  parameter int V_BP   = 10,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 22,
  parameter int X_OFF0 = 400,
  parameter int Y_OFF0 = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [10:0] x_cnt,
  output logic [9:0]  y_cnt,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic        frame_tick,
  input  logic        off_req,
  input  logic [10:0] off_x,
  input  logic [9:0]  off_y,
  output logic        off_ack,
  output logic [10:0] x_offset,
  output logic [9:0]  y_offset
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [10:0] HS_END  = 11'(H_SYNC);
  localparam logic [9:0]  VS_END  = 10'(V_SYNC);
  localparam logic [10:0] DE_X0   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] DE_X1   = 11'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0]  DE_Y0   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  DE_Y1   = 10'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [10:0] X_RST   = 11'(X_OFF0);
  localparam logic [9:0]  Y_RST   = 10'(Y_OFF0);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t      state;
  logic [10:0] pend_x;
  logic [9:0]  pend_y;

  logic        x_end;
  logic        y_end;
  logic        wrap;
  logic [10:0] x_nxt;
  logic [9:0]  y_nxt;

  always_comb begin
    x_end = (x_cnt == H_LAST);
    y_end = (y_cnt == V_LAST);
    wrap  = pix_en && x_end && y_end;
    x_nxt = x_end ? 11'd0 : x_cnt + 11'd1;
    y_nxt = y_cnt;
    if (x_end) begin
      y_nxt = y_end ? 10'd0 : y_cnt + 10'd1;
    end
  end

  // Sync and DE are decoded from the next counter values so they line up with x_cnt/y_cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      hsync_n    <= 1'b0;
      vsync_n    <= 1'b0;
      de         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (pix_en) begin
        x_cnt   <= x_nxt;
        y_cnt   <= y_nxt;
        hsync_n <= (x_nxt >= HS_END);
        vsync_n <= (y_nxt >= VS_END);
        de      <= (x_nxt >= DE_X0) && (x_nxt <= DE_X1) &&
                   (y_nxt >= DE_Y0) && (y_nxt <= DE_Y1);
      end
    end
  end

  // Offsets only move on the wrap edge, so a cube is drawn with one offset per frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      off_ack  <= 1'b0;
      pend_x   <= '0;
      pend_y   <= '0;
      x_offset <= X_RST;
      y_offset <= Y_RST;
    end else begin
      off_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (off_req) begin
            pend_x  <= off_x;
            pend_y  <= off_y;
            off_ack <= 1'b1;
            state   <= PENDING;
          end
        end
        PENDING: begin
          if (wrap) begin
            x_offset <= pend_x;
            y_offset <= pend_y;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mtl_scan_timing.sv
`default_nettype none
// Scoreboard bench for mtl_scan_timing with a shortened vertical timing to keep frames short.
module tb_mtl_scan_timing;
  localparam int H_SYNC = 30, H_BP = 16, H_ACT = 800, H_FP = 210;
  localparam int V_SYNC = 2, V_BP = 1, V_ACT = 2, V_FP = 1;
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pix_en = 1'b1;
  logic        off_req = 1'b0;
  logic [10:0] off_x = '0;
  logic [9:0]  off_y = '0;
  logic [10:0] x_cnt, x_offset;
  logic [9:0]  y_cnt, y_offset;
  logic        hsync_n, vsync_n, de, frame_tick, off_ack;

  mtl_scan_timing #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
    .X_OFF0(400), .Y_OFF0(200)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .de(de), .frame_tick(frame_tick),
    .off_req(off_req), .off_x(off_x), .off_y(off_y), .off_ack(off_ack),
    .x_offset(x_offset), .y_offset(y_offset)
  );

  always #5 clk = ~clk;

  typedef struct {int xo; int yo;} offs_t;
  offs_t tick_q[$];
  int    ack_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, mx = 0, my = 0;
  bit exp_tick = 1'b0, exp_de = 1'b0, bad = 1'b0;
  int trk_err = 0, first_bad = -1;
  int n_de = 0, n_hs = 0, n_vs = 0, n_ticks = 0;
  int last_tick_cyc = 0, prev_tick_cyc = 0;
  bit have_first = 1'b0;
  int first_x = 0, first_y = 0, last_x = 0, last_y = 0;
  int last_xo = 400, last_yo = 200;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference beam position, advanced on enabled edges.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mx <= 0; my <= 0; exp_tick <= 1'b0;
    end else begin
      exp_tick <= 1'b0;
      if (pix_en) begin
        if (mx == H_TOTAL - 1) begin
          mx <= 0;
          if (my == V_TOTAL - 1) begin
            my <= 0; exp_tick <= 1'b1;
          end else my <= my + 1;
        end else mx <= mx + 1;
      end
    end
  end

  // Monitor: continuous tracking plus scoreboard pops on ack / frame_tick.
  always @(negedge clk) begin
    exp_de = (mx >= H_SYNC + H_BP) && (mx < H_SYNC + H_BP + H_ACT) &&
             (my >= V_SYNC + V_BP) && (my < V_SYNC + V_BP + V_ACT);
    bad = (int'(x_cnt) != mx) || (int'(y_cnt) != my) ||
          (hsync_n != (mx >= H_SYNC)) || (vsync_n != (my >= V_SYNC)) ||
          (de != exp_de) || (frame_tick != exp_tick) ||
          (!reset && !frame_tick && (int'(x_offset) != last_xo || int'(y_offset) != last_yo)) ||
          (reset && (int'(x_offset) != 400 || int'(y_offset) != 200));
    if (bad) begin
      if (trk_err == 0) first_bad = cyc;
      trk_err++;
    end
    last_xo = int'(x_offset);
    last_yo = int'(y_offset);
    if (de) begin
      n_de++;
      if (!have_first) begin
        have_first = 1'b1; first_x = int'(x_cnt); first_y = int'(y_cnt);
      end
      last_x = int'(x_cnt); last_y = int'(y_cnt);
    end
    if (!hsync_n) n_hs++;
    if (!vsync_n) n_vs++;
    if (off_ack) begin
      if (ack_q.size() == 0) check("unexpected_ack", int'(off_ack), 0);
      else check("ack_cycle", cyc, ack_q.pop_front());
    end
    if (frame_tick) begin
      n_ticks++;
      prev_tick_cyc = last_tick_cyc;
      last_tick_cyc = cyc;
      if (tick_q.size() == 0) check("unexpected_tick", int'(frame_tick), 0);
      else begin
        offs_t e;
        e = tick_q.pop_front();
        check("tick_x_offset", int'(x_offset), e.xo);
        check("tick_y_offset", int'(y_offset), e.yo);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tick(input int budget);
    int b;
    bit got;
    b = n_ticks;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      if (n_ticks > b) got = 1'b1;
    end
    check("tick_within_budget", int'(got), 1);
  endtask

  task automatic wait_pos(input int px, input int py, input int budget);
    bit got;
    got = (mx == px) && (my == py);
    for (int k = 0; k < budget && !got; k++) begin
      step();
      if (mx == px && my == py) got = 1'b1;
    end
    check("reach_position", int'(got), 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x_cnt"}, int'(x_cnt), 0);
    check({tag, "_y_cnt"}, int'(y_cnt), 0);
    check({tag, "_hsync_n"}, int'(hsync_n), 0);
    check({tag, "_vsync_n"}, int'(vsync_n), 0);
    check({tag, "_de"}, int'(de), 0);
    check({tag, "_frame_tick"}, int'(frame_tick), 0);
    check({tag, "_off_ack"}, int'(off_ack), 0);
    check({tag, "_x_offset"}, int'(x_offset), 400);
    check({tag, "_y_offset"}, int'(y_offset), 200);
  endtask

  int b_de, b_hs, b_vs, b_t;

  initial begin
    #2 reset = 1'b1;
    repeat (3) step();
    check_reset_state("reset");
    reset = 1'b0;

    // One full frame with pix_en held high.
    tick_q.push_back('{400, 200});
    b_de = n_de; b_hs = n_hs; b_vs = n_vs; b_t = n_ticks;
    have_first = 1'b0;
    repeat (FRAME) step();
    check("frame_ticks", n_ticks - b_t, 1);
    check("de_count", n_de - b_de, H_ACT * V_ACT);
    check("hsync_low_count", n_hs - b_hs, H_SYNC * V_TOTAL);
    check("vsync_low_count", n_vs - b_vs, V_SYNC * H_TOTAL);
    check("de_first_x", first_x, 46);
    check("de_first_y", first_y, V_SYNC + V_BP);
    check("de_last_x", last_x, 845);
    check("de_last_y", last_y, V_SYNC + V_BP + V_ACT - 1);

    // pix_en alternating 0/1: frame period doubles.
    tick_q.push_back('{400, 200});
    b_t = n_ticks;
    for (int i = 0; i < 2 * FRAME; i++) begin
      pix_en = 1'(i % 2);
      step();
    end
    pix_en = 1'b1;
    check("toggle_ticks", n_ticks - b_t, 1);
    check("toggle_period", last_tick_cyc - prev_tick_cyc, 2 * FRAME);

    // Mid-frame request applied at the next frame boundary.
    repeat (3000) step();
    ack_q.push_back(cyc + 1);
    tick_q.push_back('{500, 100});
    off_req = 1'b1; off_x = 11'd500; off_y = 10'd100;
    step();
    off_req = 1'b0;
    check("offset_held_after_ack", int'(x_offset), 400);
    wait_tick(FRAME + 10);

    // Request on the wrap cycle, then held high through the next wrap while pending.
    wait_pos(H_TOTAL - 1, V_TOTAL - 1, FRAME + 10);
    ack_q.push_back(cyc + 1);
    tick_q.push_back('{500, 100});
    off_req = 1'b1; off_x = 11'd300; off_y = 10'd50;
    step();
    off_x = 11'd222; off_y = 10'd33;
    check("wrap_req_not_applied", int'(x_offset), 500);
    step();
    wait_pos(H_TOTAL - 1, V_TOTAL - 1, FRAME + 10);
    tick_q.push_back('{300, 50});
    ack_q.push_back(cyc + 2);
    step();
    step();
    off_req = 1'b0;
    check("applied_x_300", int'(x_offset), 300);
    check("applied_y_50", int'(y_offset), 50);
    tick_q.push_back('{222, 33});
    wait_tick(FRAME + 10);

    // Reset while a request is pending: discarded, offsets back to defaults.
    ack_q.push_back(cyc + 1);
    off_req = 1'b1; off_x = 11'd700; off_y = 10'd20;
    step();
    off_req = 1'b0;
    wait_pos(600, 3, FRAME);
    check("pre_reset_de", int'(de), 1);
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    step();
    reset = 1'b0;
    tick_q.push_back('{400, 200});
    wait_tick(FRAME + 10);
    repeat (5) step();

    check($sformatf("tracking_errors(first at cycle %0d)", first_bad), trk_err, 0);
    check("ack_queue_left", ack_q.size(), 0);
    check("tick_queue_left", tick_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
